uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the payload bits per frame.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RST, input, 1, the reset; it is synchronous and active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH, the parallel payload to transmit.
REQ-005 SHALL have port Data_Valid, input, 1, a one-cycle request strobe.
REQ-006 SHALL have port PAR_EN, input, 1, which appends a parity bit when 1.
REQ-007 SHALL have port PAR_TYP, input, 1, selecting odd parity when 1 and even parity when 0.
REQ-008 SHALL have port TX_OUT, output, 1, the registered serial line.
REQ-009 SHALL have port Busy, output, 1, a registered flag that is high while a frame is on the line.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-011 SHALL accept Data_Valid only in IDLE, and SHALL ignore it in every other state with no queuing.
REQ-012 SHALL latch P_DATA, PAR_EN and PAR_TYP on the accepting edge, and SHALL hold the latched values constant for the whole frame.
REQ-013 SHALL compute parity on the accepting edge from the latched data: even gives XOR-reduce(data), odd gives its inverse.
REQ-014 SHALL move from IDLE to START on acceptance, so that TX_OUT=0 in the cycle after Data_Valid is sampled (latency 1).
REQ-015 SHALL make START last exactly 1 cycle and then enter DATA.
REQ-016 SHALL shift the data out LSB first in DATA, one bit per cycle, for DATA_WIDTH cycles.
REQ-017 SHALL track DATA with a bit counter of width clog2(DATA_WIDTH) that clears on entry to DATA.
REQ-018 SHALL leave DATA after the last data bit, going to PARITY if latched PAR_EN=1 and to STOP otherwise.
REQ-019 SHALL drive the latched parity bit on TX_OUT during PARITY for 1 cycle, then enter STOP.
REQ-020 SHALL drive TX_OUT=1 during STOP for 1 cycle, then enter IDLE.
REQ-021 SHALL produce a frame of DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 cycles without (11 or 10 for the default).
REQ-022 SHALL drive TX_OUT=1 and Busy=0 in IDLE.
REQ-023 SHALL drive Busy=1 exactly in START, DATA, PARITY and STOP.
REQ-024 SHALL keep at least one IDLE cycle between frames.
REQ-025 SHALL start a new frame at the cycle after that IDLE cycle when Data_Valid is held or re-asserted.
REQ-026 SHALL ignore changes on PAR_EN, PAR_TYP or P_DATA during a frame.
REQ-027 SHALL produce glitch-free TX_OUT, driven only from flops.

Reset
REQ-028 SHALL, on any rising edge with RST=0, set the state to IDLE, TX_OUT=1, Busy=0, and clear the shift register, bit counter and parity register to 0.
REQ-029 SHALL let a reset asserted mid-frame abort the frame, so that TX_OUT=1 from the following cycle and no partial bits resume.
REQ-030 SHALL ignore a Data_Valid sampled in the same cycle as RST=0.

Structure
REQ-031 SHALL place the state encoding (IDLE, START, DATA, PARITY, STOP) and the frame-overhead constants in a shared uart_pkg package.
REQ-032 SHALL place the shift register, bit counter and parity register in a single sub-module uart_tx_serializer, which uart_tx_ctrl sequences via load, shift and done signals.

Verification
REQ-033 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 and Busy high for 11 cycles.
REQ-034 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit 1, 11-cycle frame.
REQ-035 SHALL cover: P_DATA=0x01, PAR_EN=0 -> TX_OUT sequence 0,1,0,0,0,0,0,0,0,1 and Busy high for 10 cycles.
REQ-036 SHALL cover: Data_Valid pulsed at frame cycle 4 with P_DATA=0xFF -> ignored, the original frame is unchanged, and Busy falls on schedule.
REQ-037 SHALL cover: RST=0 at DATA bit 3 -> the next cycle has TX_OUT=1 and Busy=0, and a fresh Data_Valid afterwards sends a complete frame.
REQ-038 SHALL cover: Data_Valid held high continuously -> back-to-back frames separated by exactly 1 IDLE cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding and frame-overhead constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int FRAME_OVERHEAD = 2;
  localparam int FRAME_OVERHEAD_PAR = 3;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload shift register, bit counter, parity register (CLK, RST active-low sync, load/shift in, bit_cur/bit_nxt/par/done out)
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  bit_cur,
  output logic                  bit_nxt,
  output logic                  par,
  output logic                  done
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sr <= '0;
      cnt <= '0;
      par <= 1'b0;
    end else if (load) begin
      sr <= data;
      cnt <= '0;
      par <= ^data ^ par_typ;
    end else if (shift) begin
      sr <= sr >> 1;
      cnt <= cnt + 1'b1;
    end
  end
  assign bit_cur = sr[0];
  assign bit_nxt = sr[DATA_WIDTH > 1 ? 1 : 0];
  assign done = cnt == CW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer (CLK, RST active-low sync, P_DATA/Data_Valid/PAR_EN/PAR_TYP in, registered TX_OUT/Busy out)
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);
  tx_state_t state, state_nxt;
  logic load, shift, done, bit_cur, bit_nxt, par, par_en_q, tx_nxt;
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .shift(shift),
    .data(P_DATA),
    .par_typ(PAR_TYP),
    .bit_cur(bit_cur),
    .bit_nxt(bit_nxt),
    .par(par),
    .done(done)
  );
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    shift = 1'b0;
    tx_nxt = 1'b1;
    case (state)
      IDLE: begin
        load = Data_Valid;
        state_nxt = Data_Valid ? START : IDLE;
        tx_nxt = !Data_Valid;
      end
      START: begin
        state_nxt = DATA;
        tx_nxt = bit_cur;
      end
      DATA: begin
        shift = !done;
        state_nxt = !done ? DATA : par_en_q ? PARITY : STOP;
        tx_nxt = !done ? bit_nxt : par_en_q ? par : 1'b1;
      end
      PARITY: state_nxt = STOP;
      STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      TX_OUT <= 1'b1;
      Busy <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      TX_OUT <= tx_nxt;
      Busy <= state_nxt != IDLE;
      if (load) par_en_q <= PAR_EN;
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] p_data = '0;
  logic data_valid = 1'b0;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic tx_out, busy;
  int n_tests = 0;
  int n_fail = 0;
  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(clk),
    .RST(rst),
    .P_DATA(p_data),
    .Data_Valid(data_valid),
    .PAR_EN(par_en),
    .PAR_TYP(par_typ),
    .TX_OUT(tx_out),
    .Busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                           input logic [15:0] exp, input int len, input int poke);
    @(negedge clk);
    data_valid = 1'b1;
    p_data = d;
    par_en = pe;
    par_typ = pt;
    @(negedge clk);
    data_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", tag, i), 32'(tx_out), 32'(exp[i]));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
      if (i == poke) begin
        data_valid = 1'b1;
        p_data = 8'hFF;
        par_en = ~pe;
        par_typ = ~pt;
      end else if (i == poke + 1) data_valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, " end busy"}, 32'(busy), 32'd0);
    chk({tag, " end tx"}, 32'(tx_out), 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset tx", 32'(tx_out), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b1;
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'h054A, 11, -1);
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 16'h074A, 11, -1);
    run_frame("01_nopar", 8'h01, 1'b0, 1'b0, 16'h0202, 10, -1);
    run_frame("3c_odd", 8'h3C, 1'b1, 1'b1, 16'h0678, 11, -1);
    run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 16'h03FE, 10, -1);
    run_frame("poke", 8'hA5, 1'b1, 1'b0, 16'h054A, 11, 4);
    @(negedge clk);
    chk("poke idle busy", 32'(busy), 32'd0);
    chk("poke idle tx", 32'(tx_out), 32'd1);
    @(negedge clk);
    data_valid = 1'b1;
    p_data = 8'hA5;
    par_en = 1'b1;
    par_typ = 1'b0;
    @(negedge clk);
    data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pre_rst tx[%0d]", i), 32'(tx_out), 32'({28'd0, 4'b1010} >> i & 1));
      @(negedge clk);
    end
    rst = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    chk("rst abort tx", 32'(tx_out), 32'd1);
    chk("rst abort busy", 32'(busy), 32'd0);
    rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    chk("rst dv ignored tx", 32'(tx_out), 32'd1);
    chk("rst dv ignored busy", 32'(busy), 32'd0);
    run_frame("after_rst", 8'hA5, 1'b1, 1'b0, 16'h054A, 11, -1);
    @(negedge clk);
    data_valid = 1'b1;
    p_data = 8'h01;
    par_en = 1'b0;
    par_typ = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 22; c++) begin
      int pos;
      logic [15:0] seq;
      pos = c % 11;
      seq = 16'h0202;
      chk($sformatf("b2b busy[%0d]", c), 32'(busy), pos < 10 ? 32'd1 : 32'd0);
      chk($sformatf("b2b tx[%0d]", c), 32'(tx_out), pos < 10 ? 32'(seq[pos]) : 32'd1);
      @(negedge clk);
    end
    data_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("drain busy", 32'(busy), 32'd0);
    chk("drain tx", 32'(tx_out), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
